periph_bus_arbiter: RTL and testbench
=====================================

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4: max consecutive owned cycles before forced hand-over when the other master waits (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1 each  master 0 (CPU) / master 1 (DMA) bus request, held high until access done.
REQ-005 rd0, wr0, addr0[31:0], wdata0[31:0]  input  master 0 access command; rd1, wr1, addr1, wdata1 likewise for master 1.
REQ-006 gnt0 / gnt1  output  1 each  registered grant, at most one high.
REQ-007 done0 / done1  output  1 each  access of that master completes this cycle.
REQ-008 rdata0 / rdata1  output  32 each  slave read data routed to the master.
REQ-009 rd, wr, addr[31:0], wdata[31:0]  output  command to the shared peripheral register bus.
REQ-010 rdata  input  32  combinational read data from the peripheral bus.

Function
REQ-011 FSM states: IDLE, OWN0, OWN1; gnt0=(state==OWN0), gnt1=(state==OWN1).
REQ-012 IDLE: no request -> stay; only reqX -> OWNX next cycle; both -> winner per REQ-020/REQ-021.
REQ-013 Grant latency: request sampled in IDLE -> gnt one cycle later; no access in the sampling cycle.
REQ-014 OWNX: rd/wr/addr/wdata = master X's inputs gated with reqX; other master's commands fully ignored.
REQ-015 No owner or owner's req low: rd=0, wr=0, addr=0, wdata=0.
REQ-016 doneX = gntX & reqX & (rdX | wrX), combinational; rdataX = rdata when gntX & rdX, else 0.
REQ-017 Owner drops req: other req high -> switch directly to other OWN next cycle (no IDLE bubble); else -> IDLE.
REQ-018 Burst counter (4 bit) counts owned cycles; cleared on any grant change or entry to IDLE.
REQ-019 Counter == BURST_MAX-1 and other req high -> switch to other OWN next cycle regardless of owner's req; other req low -> owner keeps bus, counter saturates.
REQ-020 Tie in IDLE (both req): last-owner pointer decides; winner = master not served last; pointer updates on every grant.
REQ-021 Owner's req and other's req both drop same cycle -> IDLE.
REQ-022 Write into peripheral occurs only in cycles where wr output is high; exactly one slave write per doneX cycle with wrX.

Reset
REQ-023 On the clk edge with reset high: state=IDLE, gnt0=gnt1=0, counter=0, last-owner pointer=1 (master 0 wins first tie).
REQ-024 Reset mid-access: from the next cycle rd=wr=0, done0=done1=0; in-flight access abandoned, not retried.
REQ-025 Combinational outputs (rd, wr, addr, wdata, done, rdata routing) follow state, hence 0 while in IDLE after reset.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN defined: tie rule per REQ-020 and burst hand-over per REQ-019.
REQ-027 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, master 0 wins every tie; REQ-019 hand-over applies only 1->0 (master 0 never pre-empted).

Verification
REQ-028 Reset, then req0=1 wr0=1 addr0=0x4000000C wdata0=0x5A -> gnt0=1 after 1 cycle, wr=1 addr=0x4000000C wdata=0x5A, done0=1 same cycle.
REQ-029 req0 and req1 rise same cycle after reset -> OWN0 first; req0 drops after 1 access -> gnt1=1 next cycle, no IDLE cycle.
REQ-030 BURST_MAX=4, req0 held, req1 raised at grant -> gnt0 for exactly 4 cycles then gnt1=1 (RR build); fixed-priority build: gnt0 persists.
REQ-031 Master 1 owns, rd1=1 addr1=0x40000010, slave rdata=0x000000A5 -> rdata1=0xA5, rdata0=0, done1=1.
REQ-032 Reset asserted during OWN1 write -> next cycle gnt1=0, wr=0, done1=0; following tie -> master 0 granted.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter for a shared peripheral register bus with a burst limit.
// Define ARB_ROUND_ROBIN_EN for round-robin ties and symmetric hand-over; otherwise master 0 has fixed priority.
module periph_bus_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        rd0,
    input  logic        wr0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        rd1,
    input  logic        wr1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;   // 1: master 1 was granted most recently
    logic       burst_end;
    logic       act0, act1;

    always_comb begin
        state_d   = state_q;
        burst_end = (cnt_q == CNT_LAST);
        case (state_q)
            IDLE: begin
                if (req0 && req1)
                    state_d = (RR_EN && !last_q) ? OWN1 : OWN0;
                else if (req0)
                    state_d = OWN0;
                else if (req1)
                    state_d = OWN1;
            end
            OWN0: begin
                if (!req0)
                    state_d = req1 ? OWN1 : IDLE;
                else if (RR_EN && burst_end && req1)
                    state_d = OWN1;
            end
            OWN1: begin
                if (!req1)
                    state_d = req0 ? OWN0 : IDLE;
                else if (burst_end && req0)
                    state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase

        // Counter restarts on every grant change; it saturates while nobody contends.
        cnt_d = cnt_q;
        if (state_d != state_q || state_d == IDLE)
            cnt_d = 4'd0;
        else if (!burst_end)
            cnt_d = cnt_q + 4'd1;

        last_d = last_q;
        if (state_d != state_q) begin
            if (state_d == OWN0)
                last_d = 1'b0;
            else if (state_d == OWN1)
                last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt0 = (state_q == OWN0);
    assign gnt1 = (state_q == OWN1);
    assign act0 = gnt0 & req0;
    assign act1 = gnt1 & req1;

    always_comb begin
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        if (act0) begin
            rd    = rd0;
            wr    = wr0;
            addr  = addr0;
            wdata = wdata0;
        end else if (act1) begin
            rd    = rd1;
            wr    = wr1;
            addr  = addr1;
            wdata = wdata1;
        end
    end

    assign done0  = act0 & (rd0 | wr0);
    assign done1  = act1 & (rd1 | wr1);
    assign rdata0 = (gnt0 && rd0) ? rdata : 32'd0;
    assign rdata1 = (gnt1 && rd1) ? rdata : 32'd0;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: directed scenarios plus a randomized run against a small model.
module tb_periph_bus_arbiter;

    localparam int BM = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
    logic        req1 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0, addr1 = 32'd0, wdata1 = 32'd0;
    logic [31:0] rdata = 32'd0;
    logic        gnt0, gnt1, done0, done1, rd, wr;
    logic [31:0] rdata0, rdata1, addr, wdata;

    typedef struct {
        string        nm;
        logic [133:0] v;
    } sb_t;

    sb_t sb[$];
    int  n_vec  = 0;
    int  n_miss = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter #(.BURST_MAX(BM)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    // Control word layout: {reset, req0, rd0, wr0, req1, rd1, wr1}
    task automatic drive(input logic [6:0] c);
        @(posedge clk);
        #1;
        {reset, req0, rd0, wr0, req1, rd1, wr1} = c;
    endtask

    function automatic logic [133:0] observe();
        return {gnt0, gnt1, done0, done1, rd, wr, addr, wdata, rdata0, rdata1};
    endfunction

    // e = {gnt0, gnt1, master0 access on bus, master1 access on bus}
    function automatic logic [133:0] exp_vec(input logic [3:0] e, input logic [6:0] c);
        logic        g0, g1, a0, a1, r, w, d0, d1;
        logic [31:0] a, wd, r0v, r1v;
        g0 = e[3]; g1 = e[2]; a0 = e[1]; a1 = e[0];
        r = 1'b0; w = 1'b0; a = 32'd0; wd = 32'd0;
        if (a0) begin
            r = c[4]; w = c[3]; a = addr0; wd = wdata0;
        end else if (a1) begin
            r = c[1]; w = c[0]; a = addr1; wd = wdata1;
        end
        d0  = a0 & (c[4] | c[3]);
        d1  = a1 & (c[1] | c[0]);
        r0v = (g0 && c[4]) ? rdata : 32'd0;
        r1v = (g1 && c[1]) ? rdata : 32'd0;
        return {g0, g1, d0, d1, r, w, a, wd, r0v, r1v};
    endfunction

    function automatic sb_t mk(input string nm, input logic [133:0] v);
        sb_t t;
        t.nm = nm;
        t.v  = v;
        return t;
    endfunction

    task automatic test_reset();
        logic [6:0] c[3];
        logic [3:0] e[3];
        sb_t s;
        logic [133:0] obs;
        c = '{7'b1101101, 7'b0000000, 7'b0000000};
        e = '{4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            drive(c[i]);
            sb.push_back(mk($sformatf("reset[%0d]", i), exp_vec(e[i], c[i])));
            @(negedge clk);
            s = sb.pop_front();
            obs = observe();
            n_vec++;
            if (obs !== s.v) begin
                n_miss++;
                $display("FAIL %s: got %h want %h", s.nm, obs, s.v);
            end else
                $display("ok %s %h", s.nm, obs);
        end
    endtask

    task automatic test_write();
        logic [6:0] c[4];
        logic [3:0] e[4];
        sb_t s;
        logic [133:0] obs;
        addr0 = 32'h4000000C; wdata0 = 32'h0000005A;
        addr1 = 32'h12345678; wdata1 = 32'h9ABCDEF0; rdata = 32'hDEADBEEF;
        c = '{7'b0101000, 7'b0101000, 7'b0000000, 7'b0000000};
        e = '{4'b0000, 4'b1010, 4'b1000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            drive(c[i]);
            sb.push_back(mk($sformatf("write[%0d]", i), exp_vec(e[i], c[i])));
            @(negedge clk);
            s = sb.pop_front();
            obs = observe();
            n_vec++;
            if (obs !== s.v) begin
                n_miss++;
                $display("FAIL %s: got %h want %h", s.nm, obs, s.v);
            end else
                $display("ok %s %h", s.nm, obs);
        end
    endtask

    // Master 0 was served last here, so a round-robin build hands the tie to master 1.
    task automatic test_tie_after_m0();
        logic [6:0] c[4];
        logic [3:0] e[4];
        sb_t s;
        logic [133:0] obs;
        addr0 = 32'h00000100; wdata0 = 32'h11;
        addr1 = 32'h00000200; wdata1 = 32'h22;
        c = '{7'b0101101, 7'b0101101, 7'b0000000, 7'b0000000};
        e = '{4'b0000, RR ? 4'b0101 : 4'b1010, RR ? 4'b0100 : 4'b1000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            drive(c[i]);
            sb.push_back(mk($sformatf("tie_m0last[%0d]", i), exp_vec(e[i], c[i])));
            @(negedge clk);
            s = sb.pop_front();
            obs = observe();
            n_vec++;
            if (obs !== s.v) begin
                n_miss++;
                $display("FAIL %s: got %h want %h", s.nm, obs, s.v);
            end else
                $display("ok %s %h", s.nm, obs);
        end
    endtask

    task automatic test_read();
        logic [6:0] c[4];
        logic [3:0] e[4];
        sb_t s;
        logic [133:0] obs;
        addr0 = 32'h40000020; wdata0 = 32'h0;
        addr1 = 32'h40000010; wdata1 = 32'h0; rdata = 32'h000000A5;
        c = '{7'b0010110, 7'b0010110, 7'b0000000, 7'b0000000};
        e = '{4'b0000, 4'b0101, 4'b0100, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            drive(c[i]);
            sb.push_back(mk($sformatf("read[%0d]", i), exp_vec(e[i], c[i])));
            @(negedge clk);
            s = sb.pop_front();
            obs = observe();
            n_vec++;
            if (obs !== s.v) begin
                n_miss++;
                $display("FAIL %s: got %h want %h", s.nm, obs, s.v);
            end else
                $display("ok %s %h", s.nm, obs);
        end
    endtask

    task automatic test_handover();
        logic [6:0] c[7];
        logic [3:0] e[7];
        sb_t s;
        logic [133:0] obs;
        addr0 = 32'h00000104; wdata0 = 32'h33;
        addr1 = 32'h00000208; wdata1 = 32'h44; rdata = 32'h0;
        c = '{7'b1000000, 7'b0101101, 7'b0101101, 7'b0000101, 7'b0000101, 7'b0000000, 7'b0000000};
        e = '{4'b0000, 4'b0000, 4'b1010, 4'b1000, 4'b0101, 4'b0100, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            drive(c[i]);
            sb.push_back(mk($sformatf("handover[%0d]", i), exp_vec(e[i], c[i])));
            @(negedge clk);
            s = sb.pop_front();
            obs = observe();
            n_vec++;
            if (obs !== s.v) begin
                n_miss++;
                $display("FAIL %s: got %h want %h", s.nm, obs, s.v);
            end else
                $display("ok %s %h", s.nm, obs);
        end
    endtask

    task automatic test_burst_m0();
        logic [6:0] c[10];
        logic [3:0] e[10];
        sb_t s;
        logic [133:0] obs;
        addr0 = 32'h40000040; wdata0 = 32'hA0;
        addr1 = 32'h40000044; wdata1 = 32'hA1;
        c = '{7'b1000000, 7'b0101000, 7'b0101101, 7'b0101101, 7'b0101101,
              7'b0101101, 7'b0101101, 7'b0101101, 7'b0000000, 7'b0000000};
        e = '{4'b0000, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b1010,
              RR ? 4'b0101 : 4'b1010, RR ? 4'b0101 : 4'b1010,
              RR ? 4'b0100 : 4'b1000, 4'b0000};
        for (int i = 0; i < 10; i++) begin
            drive(c[i]);
            sb.push_back(mk($sformatf("burst_m0[%0d]", i), exp_vec(e[i], c[i])));
            @(negedge clk);
            s = sb.pop_front();
            obs = observe();
            n_vec++;
            if (obs !== s.v) begin
                n_miss++;
                $display("FAIL %s: got %h want %h", s.nm, obs, s.v);
            end else
                $display("ok %s %h", s.nm, obs);
        end
    endtask

    task automatic test_burst_m1();
        logic [6:0] c[9];
        logic [3:0] e[9];
        sb_t s;
        logic [133:0] obs;
        addr0 = 32'h40000050; wdata0 = 32'hB0;
        addr1 = 32'h40000054; wdata1 = 32'hB1;
        c = '{7'b1000000, 7'b0000101, 7'b0101101, 7'b0101101, 7'b0101101,
              7'b0101101, 7'b0101101, 7'b0000000, 7'b0000000};
        e = '{4'b0000, 4'b0000, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
              4'b1010, 4'b1000, 4'b0000};
        for (int i = 0; i < 9; i++) begin
            drive(c[i]);
            sb.push_back(mk($sformatf("burst_m1[%0d]", i), exp_vec(e[i], c[i])));
            @(negedge clk);
            s = sb.pop_front();
            obs = observe();
            n_vec++;
            if (obs !== s.v) begin
                n_miss++;
                $display("FAIL %s: got %h want %h", s.nm, obs, s.v);
            end else
                $display("ok %s %h", s.nm, obs);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] c[8];
        logic [3:0] e[8];
        sb_t s;
        logic [133:0] obs;
        addr0 = 32'h40000034; wdata0 = 32'h88;
        addr1 = 32'h40000030; wdata1 = 32'h77;
        c = '{7'b1000000, 7'b0000101, 7'b0000101, 7'b1101101,
              7'b0101101, 7'b0101101, 7'b0000000, 7'b0000000};
        e = '{4'b0000, 4'b0000, 4'b0101, 4'b0101, 4'b0000, 4'b1010, 4'b1000, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            drive(c[i]);
            sb.push_back(mk($sformatf("reset_mid[%0d]", i), exp_vec(e[i], c[i])));
            @(negedge clk);
            s = sb.pop_front();
            obs = observe();
            n_vec++;
            if (obs !== s.v) begin
                n_miss++;
                $display("FAIL %s: got %h want %h", s.nm, obs, s.v);
            end else
                $display("ok %s %h", s.nm, obs);
        end
    endtask

    task automatic test_random();
        int         mst, nst, mcnt;
        bit         mlast;
        logic [6:0] c;
        logic [3:0] e;
        logic       q0, q1;
        sb_t        s;
        logic [133:0] obs;
        drive(7'b1000000);
        mst = 0; mcnt = 0; mlast = 1'b1;
        for (int i = 0; i < 300; i++) begin
            q0 = ($urandom_range(0, 3) != 0);
            q1 = ($urandom_range(0, 3) != 0);
            c  = {1'b0, q0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  q1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            drive(c);
            addr0 = $urandom; wdata0 = $urandom;
            addr1 = $urandom; wdata1 = $urandom; rdata = $urandom;
            e = {mst == 1, mst == 2, (mst == 1) && q0, (mst == 2) && q1};
            sb.push_back(mk($sformatf("rand[%0d]", i), exp_vec(e, c)));
            @(negedge clk);
            s = sb.pop_front();
            obs = observe();
            n_vec++;
            if (obs !== s.v) begin
                n_miss++;
                $display("FAIL %s: got %h want %h", s.nm, obs, s.v);
            end else
                $display("ok %s %h", s.nm, obs);
            nst = mst;
            if (mst == 0) begin
                if (q0 && q1) nst = (RR && !mlast) ? 2 : 1;
                else if (q0)  nst = 1;
                else if (q1)  nst = 2;
            end else if (mst == 1) begin
                if (!q0)                           nst = q1 ? 2 : 0;
                else if (RR && q1 && mcnt == BM-1) nst = 2;
            end else begin
                if (!q1)                     nst = q0 ? 1 : 0;
                else if (q0 && mcnt == BM-1) nst = 1;
            end
            if (nst != mst || nst == 0) mcnt = 0;
            else if (mcnt < BM-1)       mcnt = mcnt + 1;
            if (nst != mst && nst == 1) mlast = 1'b0;
            if (nst != mst && nst == 2) mlast = 1'b1;
            mst = nst;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_tie_after_m0();
        test_read();
        test_handover();
        test_burst_m0();
        test_burst_m1();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
